// File: rtl/image_tile_reader.sv
// Streams a contiguous run of 4x4 complex tiles from the image memory into the
// compute stage, absorbing the one-cycle read latency with a 2-entry skid FIFO.
module image_tile_reader #(
  parameter int ADDR_WIDTH = 13,
  parameter int CPLX_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_address,
  input  logic [ADDR_WIDTH:0]          num_tiles,
  output logic [ADDR_WIDTH-1:0]        mem_read_address,
  input  logic [16*2*CPLX_WIDTH-1:0]   mem_data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [16*2*CPLX_WIDTH-1:0]   out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int TILE_W = 16*2*CPLX_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_ctr;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH:0]   issue_left;
  logic [ADDR_WIDTH:0]   beat_left;
  logic                  inflight;
  logic [TILE_W-1:0]     fifo_mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            fifo_count;
  logic [2:0]            credit;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  final_pop;
  logic                  accept;

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (beat_left == (ADDR_WIDTH+1)'(1));
  assign busy      = (state != IDLE);
  assign pop       = out_valid && out_ready;
  assign push      = inflight;
  assign final_pop = pop && (beat_left == (ADDR_WIDTH+1)'(1));
  assign accept    = (state == IDLE) && start;

  // Occupancy after this cycle's pop, counting the read whose data lands now;
  // keeping it below 2 leaves room for the read issued this cycle.
  assign credit = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue  = (state == RUN) && (credit < 3'd2);

  // The issuing address is driven combinationally so the memory sees it in
  // the same cycle the credit decision is made.
  assign mem_read_address = issue ? addr_ctr : addr_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (num_tiles != '0)) state_nxt = RUN;
      RUN:     if (issue && (issue_left == (ADDR_WIDTH+1)'(1))) state_nxt = DRAIN;
      DRAIN:   if (final_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_ctr   <= '0;
      addr_hold  <= '0;
      issue_left <= '0;
      beat_left  <= '0;
      inflight   <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      done       <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      if (accept) begin
        addr_ctr   <= base_address;
        issue_left <= num_tiles;
        beat_left  <= num_tiles;
      end
      if (issue) begin
        addr_hold  <= addr_ctr;
        addr_ctr   <= addr_ctr + ADDR_WIDTH'(1);
        issue_left <= issue_left - (ADDR_WIDTH+1)'(1);
      end
      inflight <= issue;
      if (push) begin
        fifo_mem[wr_ptr] <= mem_data_out;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        beat_left <= beat_left - (ADDR_WIDTH+1)'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
      done <= (accept && (num_tiles == '0)) || ((state == DRAIN) && final_pop);
    end
  end

endmodule

// File: tb/tb_image_tile_reader.sv
// Directed self-checking bench for image_tile_reader with a one-cycle-latency
// memory model whose tile contents are a function of the address.
module tb_image_tile_reader;

  localparam int AW = 13;
  localparam int CW = 32;
  localparam int TW = 16*2*CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW:0]   num_tiles;
  logic [AW-1:0] mem_read_address;
  logic [TW-1:0] mem_data_out;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  image_tile_reader #(.ADDR_WIDTH(AW), .CPLX_WIDTH(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_address     (base_address),
    .num_tiles        (num_tiles),
    .mem_read_address (mem_read_address),
    .mem_data_out     (mem_data_out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] tile_of(input logic [AW-1:0] a);
    logic [TW-1:0] t;
    for (int s = 0; s < 32; s++) t[s*32 +: 32] = {3'b101, a, 16'(s*7 + 1)};
    return t;
  endfunction

  // Synchronous-read memory: data appears the cycle after the address.
  always @(posedge clk) mem_data_out <= tile_of(mem_read_address);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tile(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed_low=%0h expected_low=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // Advance one cycle, drive this cycle's inputs, let logic settle.
  task automatic step(input logic s, input logic rdy);
    @(posedge clk);
    #1;
    start     = s;
    out_ready = rdy;
    #1;
  endtask

  task automatic exp_cyc(input string tag, input logic [AW-1:0] a, input logic v,
                         input logic [AW-1:0] ta, input logic l, input logic b, input logic d);
    chk({tag, ".addr"}, 64'(mem_read_address), 64'(a));
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    if (v) chk_tile({tag, ".data"}, out_data, tile_of(ta));
    chk({tag, ".last"}, 64'(out_last), 64'(l));
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".done"}, 64'(done), 64'(d));
  endtask

  initial begin
    logic [31:0]   pat;
    logic [AW-1:0] prev_addr;
    logic [TW-1:0] prev_data;
    logic          prev_stall;
    logic          done_seen;
    int            issued;
    int            pops;

    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    base_address = '0; num_tiles = '0;
    #12;
    exp_cyc("reset", 13'h0000, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0);
    chk_tile("reset.data", out_data, '0);
    @(posedge clk); #1; reset = 1'b0;

    // Basic run
    base_address = 13'h0010; num_tiles = 14'd4;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1); exp_cyc("basic.c1", 13'h0010, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("basic.c2", 13'h0011, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("basic.c3", 13'h0012, 1'b1, 13'h0010, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("basic.c4", 13'h0013, 1'b1, 13'h0011, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("basic.c5", 13'h0013, 1'b1, 13'h0012, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("basic.c6", 13'h0013, 1'b1, 13'h0013, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("basic.c7", 13'h0013, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1); exp_cyc("basic.c8", 13'h0013, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0);

    // Address wrap
    base_address = 13'h1FFE; num_tiles = 14'd4;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1); exp_cyc("wrap.c1", 13'h1FFE, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("wrap.c2", 13'h1FFF, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("wrap.c3", 13'h0000, 1'b1, 13'h1FFE, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("wrap.c4", 13'h0001, 1'b1, 13'h1FFF, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("wrap.c5", 13'h0001, 1'b1, 13'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("wrap.c6", 13'h0001, 1'b1, 13'h0001, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("wrap.c7", 13'h0001, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1);

    // Zero length
    base_address = 13'h0777; num_tiles = 14'd0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1); exp_cyc("zero.c1", 13'h0001, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1); exp_cyc("zero.c2", 13'h0001, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0);

    // Start while busy is ignored
    base_address = 13'h0040; num_tiles = 14'd3;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1); exp_cyc("sbusy.c1", 13'h0040, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0);
    base_address = 13'h0200; num_tiles = 14'd5;
    step(1'b1, 1'b1); exp_cyc("sbusy.c2", 13'h0041, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("sbusy.c3", 13'h0042, 1'b1, 13'h0040, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1); exp_cyc("sbusy.c4", 13'h0042, 1'b1, 13'h0041, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("sbusy.c5", 13'h0042, 1'b1, 13'h0042, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("sbusy.c6", 13'h0042, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1); exp_cyc("sbusy.c7", 13'h0042, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0);

    // Backpressure with a fixed irregular ready pattern
    pat = 32'b1101_0011_1000_1011_0100_1110_0110_1010;
    base_address = 13'h0100; num_tiles = 14'd8;
    prev_addr = mem_read_address; prev_stall = 1'b0; prev_data = '0;
    issued = 0; pops = 0; done_seen = 1'b0;
    step(1'b1, pat[0]);
    for (int c = 1; c < 80; c++) begin
      step(1'b0, pat[c % 32]);
      if (prev_stall) begin
        chk("bp.stall_valid", 64'(out_valid), 64'd1);
        chk_tile("bp.stall_data", out_data, prev_data);
      end
      if (mem_read_address != prev_addr) begin
        chk("bp.issue_addr", 64'(mem_read_address), 64'(13'h0100 + 13'(issued)));
        issued++;
      end
      prev_addr = mem_read_address;
      if (out_valid) begin
        chk_tile("bp.data", out_data, tile_of(13'h0100 + 13'(pops)));
        chk("bp.last", 64'(out_last), 64'(pops == 7));
      end
      if (out_valid && out_ready) pops++;
      chk("bp.outstanding_le2", 64'(issued - pops <= 2), 64'd1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_seen = 1'b1;
        chk("bp.busy_at_done", 64'(busy), 64'd0);
        break;
      end
    end
    chk("bp.done_seen", 64'(done_seen), 64'd1);
    chk("bp.pops", 64'(pops), 64'd8);
    chk("bp.issued", 64'(issued), 64'd8);
    step(1'b0, 1'b1);
    chk("bp.done_one_cycle", 64'(done), 64'd0);

    // Reset with one tile in the FIFO and one read in flight
    base_address = 13'h0300; num_tiles = 14'd4;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0); exp_cyc("rst.c1", 13'h0300, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0); exp_cyc("rst.c2", 13'h0301, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0); exp_cyc("rst.c3", 13'h0301, 1'b1, 13'h0300, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    exp_cyc("rst.async", 13'h0000, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0);
    chk_tile("rst.async_data", out_data, '0);
    step(1'b0, 1'b1);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1);
      exp_cyc("rst.quiet", 13'h0000, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0);
    end
    base_address = 13'h0020; num_tiles = 14'd2;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1); exp_cyc("post.c1", 13'h0020, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("post.c2", 13'h0021, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("post.c3", 13'h0021, 1'b1, 13'h0020, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("post.c4", 13'h0021, 1'b1, 13'h0021, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1); exp_cyc("post.c5", 13'h0021, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_tile_reader.md
# image_tile_reader

Streams a contiguous run of 4x4 complex tiles out of the image memory block into the next compute stage with valid/ready backpressure. It drives the memory's shared read address, absorbs the one-cycle synchronous read latency, and holds fetched tiles in a 2-entry skid FIFO so a stalled consumer never loses data. It sits directly downstream of the image memory block and upstream of the FFT/multiply datapath.

## Interface
- ADDR_WIDTH, 13: image memory address width.
- CPLX_WIDTH, 32: width of each real or imaginary component.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- base_address  in  ADDR_WIDTH  first tile address; sampled with start.
- num_tiles  in  ADDR_WIDTH+1  tiles in the run; sampled with start; 0 is legal.
- mem_read_address  out  ADDR_WIDTH  read address to the image memory, all 16 banks.
- mem_data_out  in  16*2*CPLX_WIDTH  tile from memory, valid the cycle after its address is presented. Element (i,j) occupies slot 4*i+j; real part in the upper CPLX_WIDTH bits of the slot.
- out_valid  out  1  out_data holds a tile.
- out_ready  in  1  consumer accepts; a beat transfers when out_valid && out_ready.
- out_data  out  16*2*CPLX_WIDTH  tile, same packing as mem_data_out.
- out_last  out  1  current beat is the final tile of the run.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last beat transfers.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On start with num_tiles>0: latch base_address into addr_ctr, num_tiles into issue_left and beat_left; go to RUN.
  - On start with num_tiles==0: pulse done the next cycle and stay in IDLE; busy stays low.
- RUN issues one read per cycle when (fifo_count + inflight - pop) < 2.
  - inflight is 1 if a read was issued the previous cycle, else 0.
  - pop = out_valid && out_ready.
  - An issued read presents addr_ctr on mem_read_address. Then addr_ctr increments modulo 2^ADDR_WIDTH (0x1FFF wraps to 0x0000) and issue_left decrements.
  - When issue_left reaches 0, go to DRAIN.
- The cycle after an issue, mem_data_out is written into the FIFO tail. FIFO write and pop in the same cycle leave the count unchanged. The credit rule guarantees the FIFO never overflows.
- out_data always shows the FIFO head. beat_left decrements on each pop. out_last = out_valid && beat_left==1.
- DRAIN: when the final pop occurs, return to IDLE, drop busy, and assert done for exactly one cycle in the following cycle.
- start while busy is ignored and does not disturb the run.
- mem_read_address holds its last value when no read is issued. No read enable exists; the memory reads every cycle and the block discards unrequested data.
- Reset, including mid-run: state=IDLE, FIFO emptied, inflight cleared, any in-flight read discarded. All outputs are 0: mem_read_address=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.

## Timing
- start accepted at cycle 0. First address is presented at cycle 1, data is captured at the end of cycle 2, and out_valid is high at cycle 3. First-beat latency is 3 cycles.
- With out_ready held high: one tile per cycle sustained. An N-tile run ends its last beat at cycle N+2, with done at cycle N+3.
- out_valid and out_data stay stable while out_valid && !out_ready.
- Taking out_ready low at most 2 further reads complete into the FIFO; issue stalls. On release, the stored data drains first, with no bubble beyond the credit rule.
- Pop of an entry, FIFO write, and read issue may all occur in the same cycle.
- The 2*CPLX_WIDTH-bit slot packing passes through unmodified; the block does no arithmetic on data.

## Test plan
- Basic run: base=0x0010, num_tiles=4, out_ready=1. Expect addresses 0x10..0x13 on cycles 1..4, beats on cycles 3..6 with tile data equal to memory contents, out_last on cycle 6, done on cycle 7.
- Wrap: base=0x1FFE, num_tiles=4. Expect addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 and the 4 tiles in that order.
- Backpressure: num_tiles=8, random out_ready at 50%. Expect all 8 tiles in order, no duplicates or drops, out_data stable during stalls, and at most 2 issued-but-unpopped reads at any time.
- Zero length: start with num_tiles=0. Expect done on cycle 1, busy never high, out_valid never high.
- Start while busy: a second start mid-run with different base and count. Expect it ignored and the original sequence unchanged.
- Reset mid-run: assert reset with 1 tile in the FIFO and 1 read in flight. Expect all outputs 0 immediately, nothing emitted after release, and a subsequent start of 2 tiles behaving as in the basic run.
